// File: rtl/painterengine_gpu_frame_fetcher_if.sv
// Reader-side bus of the GPU frame fetcher: burst address/length out, run control out,
// completion and failure status back from the DMA reader.
interface painterengine_gpu_frame_fetcher_if;
    logic [31:0] o_wire_reader_address;
    logic [31:0] o_wire_reader_length;
    logic        o_wire_reader_resetn;
    logic        i_wire_reader_done;
    logic        i_wire_reader_error;

    modport master (
        output o_wire_reader_address, o_wire_reader_length, o_wire_reader_resetn,
        input  i_wire_reader_done, i_wire_reader_error
    );

    modport slave (
        input  o_wire_reader_address, o_wire_reader_length, o_wire_reader_resetn,
        output i_wire_reader_done, i_wire_reader_error
    );
endinterface

// File: rtl/painterengine_gpu_frame_fetcher.sv
// Multi-frame framebuffer fetcher: walks a clipped, strided region and issues FIFO-gated DMA bursts.
// Optional burst retry is enabled by defining PAINTERENGINE_GPU_FETCH_RETRY_EN.
module painterengine_gpu_frame_fetcher #(
    parameter int BLOCK_SIZE      = 64,
    parameter int BYTES_PER_PIXEL = 4,
    parameter int COUNT_WIDTH     = 8,
    parameter int RETRY_LIMIT     = 3
) (
    input  logic                   i_wire_clock,
    input  logic                   i_wire_resetn,
    input  logic                   i_wire_enable,
    input  logic                   i_wire_frame_start,
    input  logic [31:0]            i_wire_image_address,
    input  logic [15:0]            i_wire_image_stride,
    input  logic [15:0]            i_wire_clip_width,
    input  logic [15:0]            i_wire_clip_height,
    input  logic [COUNT_WIDTH-1:0] i_wire_fifo_free_count,
    painterengine_gpu_frame_fetcher_if.master reader,
    output logic                   o_wire_frame_done,
    output logic [31:0]            o_wire_state
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CALC1  = 4'd1,
        ST_CALC2  = 4'd2,
        ST_WAIT   = 4'd3,
        ST_STREAM = 4'd4,
        ST_CHECK  = 4'd5,
        ST_DONE   = 4'd6,
        ST_ERROR  = 4'd7
    } state_t;

    localparam int          BPP_SHIFT = (BYTES_PER_PIXEL == 4) ? 2 : 1;
    localparam logic [15:0] BLOCK_LEN = 16'(BLOCK_SIZE);

    state_t      state;
    logic [31:0] base_q;
    logic [15:0] stride_q, width_q, height_q;
    logic [15:0] x_q, y_q;
    logic [31:0] row_off_q, col_adr_q;
    logic [15:0] frame_count_q;
    logic        overrun_q, error_q;

`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
    localparam int RW = $clog2(RETRY_LIMIT + 2);
    logic [RW-1:0] retry_q;
`endif

    logic [15:0] remaining, burst_len, x_next, y_next;
    logic        idle_like, fifo_ok;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign remaining = width_q - x_q;
    assign burst_len = (remaining > BLOCK_LEN) ? BLOCK_LEN : remaining;
    assign x_next    = x_q + reader.o_wire_reader_length[15:0];
    assign y_next    = y_q + 16'd1;
    assign fifo_ok   = 32'(i_wire_fifo_free_count) >= reader.o_wire_reader_length;

    assign o_wire_state = {frame_count_q, 10'd0, error_q, overrun_q, state};

    // NOTE: every register here is written with <= so all next-state values derive from the
    // pre-edge state; a blocking = would let later statements see half-updated values.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state                        <= ST_IDLE;
            base_q                       <= '0;
            stride_q                     <= '0;
            width_q                      <= '0;
            height_q                     <= '0;
            x_q                          <= '0;
            y_q                          <= '0;
            row_off_q                    <= '0;
            col_adr_q                    <= '0;
            frame_count_q                <= '0;
            overrun_q                    <= 1'b0;
            error_q                      <= 1'b0;
            o_wire_frame_done            <= 1'b0;
            reader.o_wire_reader_address <= '0;
            reader.o_wire_reader_length  <= '0;
            reader.o_wire_reader_resetn  <= 1'b0;
`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
            retry_q                      <= '0;
`endif
        end else begin
            o_wire_frame_done <= 1'b0;
            // A start request while a frame is in flight is dropped but remembered.
            if (i_wire_enable && i_wire_frame_start && !idle_like)
                overrun_q <= 1'b1;

            if (!i_wire_enable) begin
                state                       <= ST_IDLE;
                reader.o_wire_reader_resetn <= 1'b0;
`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
                retry_q                     <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (i_wire_frame_start) begin
                            base_q   <= i_wire_image_address;
                            stride_q <= i_wire_image_stride;
                            width_q  <= i_wire_clip_width;
                            height_q <= i_wire_clip_height;
                            x_q      <= '0;
                            y_q      <= '0;
`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
                            retry_q  <= '0;
`endif
                            if (i_wire_clip_width == '0 || i_wire_clip_height == '0) begin
                                state             <= ST_DONE;
                                o_wire_frame_done <= 1'b1;
                            end else begin
                                state <= ST_CALC1;
                            end
                        end
                    end
                    ST_CALC1: begin
                        row_off_q <= (32'(y_q) * 32'(stride_q)) << BPP_SHIFT;
                        col_adr_q <= base_q + (32'(x_q) << BPP_SHIFT);
                        state     <= ST_CALC2;
                    end
                    ST_CALC2: begin
                        reader.o_wire_reader_address <= col_adr_q + row_off_q;
                        reader.o_wire_reader_length  <= 32'(burst_len);
                        state                        <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (fifo_ok) begin
                            reader.o_wire_reader_resetn <= 1'b1;
                            state                       <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (reader.i_wire_reader_error) begin
                            reader.o_wire_reader_resetn <= 1'b0;
                            error_q                     <= 1'b1;
`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
                            if (retry_q == RW'(RETRY_LIMIT)) begin
                                state <= ST_ERROR;
                            end else begin
                                retry_q <= retry_q + 1'b1;
                                state   <= ST_WAIT;
                            end
`else
                            state <= ST_ERROR;
`endif
                        end else if (reader.i_wire_reader_done) begin
                            reader.o_wire_reader_resetn <= 1'b0;
                            x_q                         <= x_next;
                            state                       <= ST_CHECK;
`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
                            retry_q                     <= '0;
`endif
                        end
                    end
                    ST_CHECK: begin
                        reader.o_wire_reader_resetn <= 1'b0;
                        if (x_q == width_q) begin
                            x_q <= '0;
                            y_q <= y_next;
                            if (y_next == height_q) begin
                                state             <= ST_DONE;
                                o_wire_frame_done <= 1'b1;
                                frame_count_q     <= frame_count_q + 16'd1;
                            end else begin
                                state <= ST_CALC1;
                            end
                        end else begin
                            state <= ST_CALC1;
                        end
                    end
                    ST_ERROR: begin
                        reader.o_wire_reader_resetn <= 1'b0;
                        error_q                     <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_frame_fetcher.sv
// Randomized self-checking bench for painterengine_gpu_frame_fetcher against a burst-list model
// derived from the region geometry; honours PAINTERENGINE_GPU_FETCH_RETRY_EN when defined.
module tb_painterengine_gpu_frame_fetcher;
    localparam int BLOCK_SIZE  = 64;
    localparam int BPP         = 4;
    localparam int COUNT_WIDTH = 8;
    localparam int RETRY_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] image_address = '0;
    logic [15:0] stride = '0, width = '0, height = '0;
    logic [COUNT_WIDTH-1:0] free_count = '0;
    logic        frame_done;
    logic [31:0] state_word;

    painterengine_gpu_frame_fetcher_if rd_if ();

    painterengine_gpu_frame_fetcher #(
        .BLOCK_SIZE(BLOCK_SIZE), .BYTES_PER_PIXEL(BPP),
        .COUNT_WIDTH(COUNT_WIDTH), .RETRY_LIMIT(RETRY_LIMIT)
    ) dut (
        .i_wire_clock(clk),
        .i_wire_resetn(rstn),
        .i_wire_enable(enable),
        .i_wire_frame_start(frame_start),
        .i_wire_image_address(image_address),
        .i_wire_image_stride(stride),
        .i_wire_clip_width(width),
        .i_wire_clip_height(height),
        .i_wire_fifo_free_count(free_count),
        .reader(rd_if),
        .o_wire_frame_done(frame_done),
        .o_wire_state(state_word)
    );

    always #5 clk = ~clk;

    wire        rn     = rd_if.o_wire_reader_resetn;
    wire [31:0] rd_adr = rd_if.o_wire_reader_address;
    wire [31:0] rd_len = rd_if.o_wire_reader_length;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    burst_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     exp_frames = 0;
    bit     exp_overrun = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference burst list: every row split into BLOCK_SIZE chunks, addresses from plain arithmetic.
    function automatic void build_expected(input logic [31:0] base, input int s, input int w, input int h);
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x += BLOCK_SIZE) begin
                burst_t b;
                b.addr = base + 32'(longint'(y) * s * BPP) + 32'(x * BPP);
                b.len  = 32'((w - x < BLOCK_SIZE) ? (w - x) : BLOCK_SIZE);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic do_reset();
        rstn = 1'b0; enable = 1'b0; frame_start = 1'b0; free_count = '0;
        rd_if.i_wire_reader_done = 1'b0; rd_if.i_wire_reader_error = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1; enable = 1'b1;
        @(negedge clk);
        exp_frames = 0; exp_overrun = 0;
    endtask

    task automatic start_frame(input logic [31:0] base, input int s, input int w, input int h);
        image_address = base; stride = 16'(s); width = 16'(w); height = 16'(h);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_launch(input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rn) ok = 1;
        end
        if (!ok) check({tag, "_launch_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_done();
        rd_if.i_wire_reader_done = 1'b1;
        @(negedge clk);
        rd_if.i_wire_reader_done = 1'b0;
    endtask

    task automatic pulse_error();
        rd_if.i_wire_reader_error = 1'b1;
        @(negedge clk);
        rd_if.i_wire_reader_error = 1'b0;
    endtask

    // Runs one frame with a reactive reader model; fixed_free < 0 or fixed_delay == 0 mean random.
    task automatic run_frame(input string tag, input logic [31:0] base, input int s, input int w,
                             input int h, input int fixed_free, input int fixed_delay,
                             input bit inject_overrun);
        int cycles = 0, cnt = 0, low_run = 0, launches = 0, dones = 0, first_launch = 0, extra = 0;
        bit prev_rn = 0, overrun_sent = 0;
        build_expected(base, s, w, h);
        free_count = (fixed_free >= 0) ? COUNT_WIDTH'(fixed_free) : COUNT_WIDTH'($urandom_range(0, 255));
        image_address = base; stride = 16'(s); width = 16'(w); height = 16'(h);
        frame_start = 1'b1;
        while (dones == 0 && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            frame_start = 1'b0;
            rd_if.i_wire_reader_done = 1'b0;
            if (rn && !prev_rn) begin
                launches++;
                if (launches == 1) first_launch = cycles;
                else check({tag, "_reset_gap"}, 32'(low_run >= 4), 32'd1);
                check({tag, "_free_ok"}, 32'(32'(free_count) >= rd_len), 32'd1);
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_burst"}, rd_adr, 32'hFFFF_FFFF);
                end else begin
                    burst_t b = exp_q.pop_front();
                    check({tag, "_addr"}, rd_adr, b.addr);
                    check({tag, "_len"}, rd_len, b.len);
                end
                cnt = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
                if (inject_overrun && !overrun_sent) begin
                    frame_start = 1'b1;
                    overrun_sent = 1;
                end
            end
            if (rn) begin
                low_run = 0;
                cnt--;
                if (cnt == 0) rd_if.i_wire_reader_done = 1'b1;
            end else begin
                low_run++;
            end
            if (frame_done) begin
                dones++;
                check({tag, "_done_state"}, 32'(state_word[3:0]), 32'd6);
            end
            prev_rn = rn;
            free_count = (fixed_free >= 0) ? COUNT_WIDTH'(fixed_free) : COUNT_WIDTH'($urandom_range(0, 255));
        end
        rd_if.i_wire_reader_done = 1'b0;
        if (dones == 0) check({tag, "_frame_timeout"}, 32'd0, 32'd1);
        if (fixed_free >= BLOCK_SIZE) check({tag, "_first_latency"}, 32'(first_launch), 32'd4);
        check({tag, "_all_bursts"}, 32'(exp_q.size()), 32'd0);
        exp_frames++;
        check({tag, "_frame_count"}, 32'(state_word[31:16]), 32'(exp_frames));
        check({tag, "_overrun"}, 32'(state_word[4]), 32'(exp_overrun));
        repeat (8) begin
            @(negedge clk);
            if (rn || frame_done) extra++;
        end
        check({tag, "_quiet_after"}, 32'(extra), 32'd0);
    endtask

    initial begin
        bit ok;
        rd_if.i_wire_reader_done = 1'b0;
        rd_if.i_wire_reader_error = 1'b0;

        // Reset values
        do_reset();
        check("rst_addr", rd_adr, 32'd0);
        check("rst_len", rd_len, 32'd0);
        check("rst_resetn", 32'(rn), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_state", state_word, 32'd0);

        // Two-row frame with a fixed reader latency and ample FIFO space
        run_frame("basic", 32'h1000, 128, 100, 2, 128, 5, 0);

        // FIFO back-pressure holds WAIT until enough space
        do_reset();
        free_count = 8'd20;
        start_frame(32'h2000, 64, 64, 1);
        repeat (10) @(negedge clk);
        check("wait_resetn", 32'(rn), 32'd0);
        check("wait_state", 32'(state_word[3:0]), 32'd3);
        free_count = 8'd64;
        @(negedge clk);
        check("wait_launch", 32'(rn), 32'd1);
        check("wait_addr", rd_adr, 32'h2000);
        check("wait_len", rd_len, 32'd64);
        pulse_done();
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (frame_done) ok = 1;
        end
        check("wait_frame_done", 32'(ok), 32'd1);
        check("wait_frame_count", 32'(state_word[31:16]), 32'd1);

        // Empty regions complete immediately without reader activity
        do_reset();
        start_frame(32'h3000, 16, 0, 5);
        check("zero_w_done", 32'(frame_done), 32'd1);
        check("zero_w_state", 32'(state_word[3:0]), 32'd6);
        @(negedge clk);
        check("zero_w_pulse", 32'(frame_done), 32'd0);
        start_frame(32'h3000, 16, 10, 0);
        check("zero_h_done", 32'(frame_done), 32'd1);
        ok = 0;
        repeat (6) begin
            @(negedge clk);
            if (rn) ok = 1;
        end
        check("zero_no_reader", 32'(ok), 32'd0);

        // Frame start during a burst is ignored but flagged
        do_reset();
        exp_overrun = 1;
        run_frame("overrun", 32'h1000, 128, 100, 2, 128, 3, 1);

        // Reader error on the second burst
        do_reset();
        free_count = 8'd128;
        start_frame(32'h1000, 128, 100, 2);
        wait_launch("err_b1", ok);
        check("err_b1_addr", rd_adr, 32'h1000);
        pulse_done();
        wait_launch("err_b2", ok);
        check("err_b2_addr", rd_adr, 32'h1100);
`ifdef PAINTERENGINE_GPU_FETCH_RETRY_EN
        for (int r = 0; r < RETRY_LIMIT; r++) begin
            pulse_error();
            check("retry_wait_state", 32'(state_word[3:0]), 32'd3);
            check("retry_resetn_low", 32'(rn), 32'd0);
            check("retry_sticky", 32'(state_word[5]), 32'd1);
            wait_launch("retry", ok);
            check("retry_addr", rd_adr, 32'h1100);
            check("retry_len", rd_len, 32'd36);
        end
`endif
        pulse_error();
        check("err_state", 32'(state_word[3:0]), 32'd7);
        check("err_sticky", 32'(state_word[5]), 32'd1);
        check("err_resetn", 32'(rn), 32'd0);
        repeat (3) @(negedge clk);
        check("err_hold", 32'(state_word[3:0]), 32'd7);
        enable = 1'b0;
        @(negedge clk);
        check("err_exit_state", 32'(state_word[3:0]), 32'd0);
        check("err_sticky_kept", 32'(state_word[5]), 32'd1);

        // Enable dropped mid-burst, then a clean frame from the origin
        do_reset();
        free_count = 8'd128;
        start_frame(32'h4000, 256, 150, 3);
        wait_launch("en_drop", ok);
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_resetn", 32'(rn), 32'd0);
        check("en_drop_state", 32'(state_word[3:0]), 32'd0);
        enable = 1'b1;
        run_frame("after_en", 32'h4000, 256, 150, 3, -1, 0, 0);

        // Asynchronous reset mid-burst, then a clean frame from the origin
        free_count = 8'd128;
        start_frame(32'h5000, 100, 80, 2);
        wait_launch("async", ok);
        #2 rstn = 1'b0;
        #1;
        check("async_resetn", 32'(rn), 32'd0);
        check("async_state", state_word, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_frames = 0; exp_overrun = 0;
        @(negedge clk);
        run_frame("after_rst", 32'h5000, 100, 80, 2, -1, 0, 0);

        // Randomized geometry, including a wrapping base address
        for (int n = 0; n < 6; n++) begin
            logic [31:0] base;
            int s, w, h;
            base = (n == 0) ? 32'hFFFF_FF00 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            s = int'($urandom_range(1, 400));
            w = int'($urandom_range(1, 200));
            h = int'($urandom_range(1, 4));
            run_frame("rand", base, s, w, h, -1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
